// File: rtl/fifo_uart_tx_if.sv
// Read-side handshake between the async FIFO and the UART transmit stage.
// The FIFO side uses master; the transmitter uses slave.
interface fifo_uart_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_empty;
  logic                  rd_inc;

  modport master (
    output rd_data,
    output rd_empty,
    input  rd_inc
  );

  modport slave (
    input  rd_data,
    input  rd_empty,
    output rd_inc
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// UART transmitter fed from the read side of an async FIFO.
// Sends one serial bit per clock: start, data LSB first, optional parity, stop.
module fifo_uart_tx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  fifo_uart_tx_if.slave        fifo,
  input  logic                 par_en,
  input  logic                 par_typ,
  output logic                 tx_out,
  output logic                 busy
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state_q, state_n;
  logic [DATA_WIDTH-1:0] shift_q, shift_n;
  logic [CW-1:0]         cnt_q, cnt_n;
  logic                  par_en_q, par_en_n;
  logic                  par_bit_q, par_bit_n;
  logic                  inc_q, inc_n;
  logic                  tx_n, busy_n;
  logic                  pop;

  assign fifo.rd_inc = inc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      inc_q     <= 1'b0;
      tx_out    <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_n;
      shift_q   <= shift_n;
      cnt_q     <= cnt_n;
      par_en_q  <= par_en_n;
      par_bit_q <= par_bit_n;
      inc_q     <= inc_n;
      tx_out    <= tx_n;
      busy      <= busy_n;
    end
  end

  // A pop is taken from IDLE or at the end of STOP, so back-to-back frames have no gap.
  always_comb begin
    state_n   = state_q;
    shift_n   = shift_q;
    cnt_n     = cnt_q;
    par_en_n  = par_en_q;
    par_bit_n = par_bit_q;
    inc_n     = 1'b0;
    pop       = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo.rd_empty) pop = 1'b1;
      end
      START: begin
        state_n = DATA;
        cnt_n   = '0;
      end
      DATA: begin
        if (cnt_q == CW'(DATA_WIDTH - 1)) begin
          state_n = par_en_q ? PARITY : STOP;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      PARITY: begin
        state_n = STOP;
      end
      STOP: begin
        if (!fifo.rd_empty) pop = 1'b1;
        else                state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    if (pop) begin
      state_n   = START;
      shift_n   = fifo.rd_data;
      par_en_n  = par_en;
      par_bit_n = (^fifo.rd_data) ^ par_typ;
      inc_n     = 1'b1;
    end

    // Line level is registered, so it is chosen from the state being entered.
    tx_n   = 1'b1;
    busy_n = (state_n != IDLE);
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[cnt_n];
      PARITY:  tx_n = par_bit_n;
      default: tx_n = 1'b1;
    endcase
  end

endmodule
